// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and single-outstanding instruction fetcher
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              issue_ready,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [3:0]        cond,
  output logic [1:0]        op,
  output logic [5:0]        funct,
  output logic [3:0]        rd,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus8
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = REQ;
      REQ:     if (imem_ack) state_next = HOLD;
      HOLD:    if (issue_ready) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state == REQ);
    instr_valid = (state == HOLD);
  end

  // Redirect and sequential advance happen only when the held word is consumed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      if (state == REQ && imem_ack) instr <= imem_rdata;
      if (state == HOLD && issue_ready) begin
        if (pc_src) pc <= {branch_target[ADDR_W-1:2], 2'b00};
        else        pc <= pc + ADDR_W'(4);
      end
    end
  end

  assign imem_addr = pc;
  assign pc_plus8  = pc + ADDR_W'(8);
  assign cond      = instr[31:28];
  assign op        = instr[27:26];
  assign funct     = instr[25:20];
  assign rd        = instr[15:12];

endmodule
